// File: rtl/core_defs.sv
// Shared core types: decode packet layout and fetch FSM encoding.
`define RESET_PC_DEFAULT 32'h80000000

package core_defs;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } fd_interface_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/core_fetch.sv
// RV32 instruction fetch: one outstanding imem read, single output register
// toward decode, redirect handling and misaligned/bus-error fault packets.
module core_fetch
  import core_defs::*;
#(
  parameter logic [31:0] RESET_PC = `RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [31:0]   imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  input  logic          imem_rsp_err,
  output logic          fd_valid,
  input  logic          fd_ready,
  output fd_interface_t fd_out,
  output logic          fd_fault,
  output logic          fd_fault_misaligned
);

  fetch_state_e  state;
  fetch_state_e  state_next;
  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [31:0]   pc_plus4;
  logic          fd_valid_next;
  fd_interface_t fd_out_next;
  logic          fault_next;
  logic          misaligned_next;
  logic          out_free;
  logic          req_fire;
  logic          outstanding;

  assign pc_plus4       = pc + 32'd4;
  assign out_free       = !fd_valid || fd_ready;
  assign imem_req_valid = !rst && !redirect_valid && (state == S_REQ) &&
                          (pc[1:0] == 2'b00) && out_free;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign outstanding    = (state == S_WAIT) || (state == S_DROP) || req_fire;

  // Next-state, next-PC and output-register update
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    fd_valid_next   = fd_valid && !fd_ready;
    fd_out_next     = fd_out;
    fault_next      = fd_fault;
    misaligned_next = fd_fault_misaligned;

    case (state)
      S_REQ: begin
        if (pc[1:0] != 2'b00) begin
          // A held packet must stay stable, so the fault waits for a free slot
          if (out_free) begin
            fd_valid_next   = 1'b1;
            fd_out_next     = '{instr: 32'h0, pc: pc, npc: pc_plus4};
            fault_next      = 1'b1;
            misaligned_next = 1'b1;
            state_next      = S_HALT;
          end else begin
            state_next = S_REQ;
          end
        end else if (req_fire) begin
          state_next = S_WAIT;
        end else begin
          state_next = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          fd_valid_next   = 1'b1;
          fd_out_next     = '{instr: (imem_rsp_err ? 32'h0 : imem_rsp_data),
                              pc: pc, npc: pc_plus4};
          fault_next      = imem_rsp_err;
          misaligned_next = 1'b0;
          if (imem_rsp_err) begin
            state_next = S_HALT;
          end else begin
            pc_next    = pc_plus4;
            state_next = S_REQ;
          end
        end else begin
          state_next = S_WAIT;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) begin
          state_next = S_REQ;
        end else begin
          state_next = S_DROP;
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_REQ;
      end
    endcase

    // Redirect discards any pending packet and any in-flight response
    if (redirect_valid) begin
      pc_next       = redirect_pc;
      fd_valid_next = 1'b0;
      if (outstanding && !imem_rsp_valid) begin
        state_next = S_DROP;
      end else begin
        state_next = S_REQ;
      end
    end else begin
      pc_next = pc_next;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_REQ;
      pc                  <= RESET_PC;
      fd_valid            <= 1'b0;
      fd_out              <= '0;
      fd_fault            <= 1'b0;
      fd_fault_misaligned <= 1'b0;
    end else begin
      state               <= state_next;
      pc                  <= pc_next;
      fd_valid            <= fd_valid_next;
      fd_out              <= fd_out_next;
      fd_fault            <= fault_next;
      fd_fault_misaligned <= misaligned_next;
    end
  end

endmodule

// File: tb/tb_core_fetch.sv
// Directed, cycle-by-cycle bench for core_fetch: a vector table of
// per-cycle inputs and expected outputs, plus reset sequences.
module tb_core_fetch;
  import core_defs::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          imem_rsp_err;
  logic          fd_valid;
  logic          fd_ready;
  fd_interface_t fd_out;
  logic          fd_fault;
  logic          fd_fault_misaligned;

  int checks = 0;
  int fails  = 0;

  core_fetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .fd_valid(fd_valid), .fd_ready(fd_ready), .fd_out(fd_out),
    .fd_fault(fd_fault), .fd_fault_misaligned(fd_fault_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rqr;
    logic        rsv;
    logic [31:0] rsd;
    logic        rse;
    logic        fdr;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic        e_flt;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rv, input logic [31:0] rpc, input logic rqr,
                     input logic rsv, input logic [31:0] rsd, input logic rse,
                     input logic fdr, input logic e_rqv, input logic [31:0] e_addr,
                     input logic e_fv, input logic [31:0] e_instr,
                     input logic [31:0] e_pc, input logic [31:0] e_npc,
                     input logic e_flt, input logic e_mis);
    vec_t v;
    v = '{rv, rpc, rqr, rsv, rsd, rse, fdr, e_rqv, e_addr, e_fv, e_instr,
          e_pc, e_npc, e_flt, e_mis};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0; imem_rsp_err = 1'b0; fd_ready = 1'b1;
  endtask

  localparam logic [31:0] NOP = 32'h00000013;

  initial begin
    // Normal fetch from reset with a 1-cycle memory
    add(0, 0, 1, 0, 0,   0, 1,  1, 32'h80000000, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, NOP, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  1, 32'h80000004, 1, NOP, 32'h80000000, 32'h80000004, 0, 0);
    add(0, 0, 1, 1, NOP, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    // Decode back-pressure for 5 cycles
    for (int k = 0; k < 5; k++)
      add(0, 0, 1, 0, 0, 0, 0,  0, 0, 1, NOP, 32'h80000004, 32'h80000008, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  1, 32'h80000008, 1, NOP, 32'h80000004, 32'h80000008, 0, 0);
    // Redirect in S_WAIT, response 3 cycles later is dropped
    add(1, 32'h80000100, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 32'hDEADBEEF, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  1, 32'h80000100, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 32'h00100093, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  1, 32'h80000104, 1, 32'h00100093, 32'h80000100, 32'h80000104, 0, 0);
    // Redirect coinciding with the response
    add(1, 32'h80000200, 1, 1, 32'h11111111, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  1, 32'h80000200, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, NOP, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    // Redirect to a misaligned target while a packet is held
    add(1, 32'h80000102, 1, 0, 0, 0, 0,  0, 0, 1, NOP, 32'h80000200, 32'h80000204, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 0,  0, 0, 1, 32'h0, 32'h80000102, 32'h80000106, 1, 1);
    add(0, 0, 1, 0, 0,   0, 1,  0, 0, 1, 32'h0, 32'h80000102, 32'h80000106, 1, 1);
    add(0, 0, 1, 0, 0,   0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h80000000, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  1, 32'h80000000, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, NOP, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  1, 32'h80000004, 1, NOP, 32'h80000000, 32'h80000004, 0, 0);
    add(0, 0, 1, 1, NOP, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  1, 32'h80000008, 1, NOP, 32'h80000004, 32'h80000008, 0, 0);
    // Bus error at 80000008 halts fetching
    add(0, 0, 1, 1, 32'h00000BAD, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  0, 0, 1, 32'h0, 32'h80000008, 32'h8000000C, 1, 0);
    add(0, 0, 1, 0, 0,   0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    // PC wrap at the top of the address space, plus a memory stall
    add(1, 32'hFFFFFFFC, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, NOP, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 1,  1, 32'h00000000, 1, NOP, 32'hFFFFFFFC, 32'h00000000, 0, 0);
    add(0, 0, 1, 0, 0,   0, 1,  1, 32'h00000000, 0, 0, 0, 0, 0, 0);

    // Reset, with a redirect asserted that reset must override
    idle_inputs();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h12345678;
    @(negedge clk); #1;
    chk("rst_fd_valid", -1, {31'h0, fd_valid}, 32'h0);
    chk("rst_req_valid", -1, {31'h0, imem_req_valid}, 32'h0);
    chk("rst_fault", -1, {30'h0, fd_fault, fd_fault_misaligned}, 32'h0);
    chk("rst_fd_instr", -1, fd_out.instr, 32'h0);
    chk("rst_fd_pc", -1, fd_out.pc, 32'h0);
    chk("rst_fd_npc", -1, fd_out.npc, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = 1'b0;
      redirect_valid = vecs[i].rv;  redirect_pc = vecs[i].rpc;
      imem_req_ready = vecs[i].rqr; imem_rsp_valid = vecs[i].rsv;
      imem_rsp_data = vecs[i].rsd;  imem_rsp_err = vecs[i].rse;
      fd_ready = vecs[i].fdr;
      #1;
      chk("req_valid", i, {31'h0, imem_req_valid}, {31'h0, vecs[i].e_rqv});
      if (vecs[i].e_rqv) chk("req_addr", i, imem_req_addr, vecs[i].e_addr);
      chk("fd_valid", i, {31'h0, fd_valid}, {31'h0, vecs[i].e_fv});
      if (vecs[i].e_fv) begin
        chk("fd_instr", i, fd_out.instr, vecs[i].e_instr);
        chk("fd_pc", i, fd_out.pc, vecs[i].e_pc);
        chk("fd_npc", i, fd_out.npc, vecs[i].e_npc);
        chk("fd_fault", i, {31'h0, fd_fault}, {31'h0, vecs[i].e_flt});
        chk("fd_misaligned", i, {31'h0, fd_fault_misaligned}, {31'h0, vecs[i].e_mis});
      end
    end

    // Reset mid-S_WAIT restarts fetching at the reset PC
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_fd_valid", -2, {31'h0, fd_valid}, 32'h0);
    chk("rst2_req_valid", -2, {31'h0, imem_req_valid}, 32'h1);
    chk("rst2_req_addr", -2, imem_req_addr, 32'h80000000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/core_fetch.md
# core_fetch

Instruction fetch stage for the RV32 core. Owns the architectural fetch PC, issues single-word reads on a valid/ready instruction-memory port, and delivers `fd_interface_t` packets to decode via a valid/ready handshake. Redirects from execute/trap logic are handled without delivering stale instructions, and misaligned-PC and bus-error faults are reported to decode.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: fetch PC after reset; must be word aligned.

Ports:
- Reset is synchronous and active-high, on one clock.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous active-high reset.
- `redirect_valid`  in  1: load new fetch PC this cycle; highest priority.
- `redirect_pc`  in  32: target PC.
- `imem_req_valid`  out  1: read request.
- `imem_req_ready`  in  1: memory accepts request.
- `imem_req_addr`  out  32: word address (`pc`).
- `imem_rsp_valid`  in  1: read data returned; always accepted, no back-pressure.
- `imem_rsp_data`  in  32: instruction word.
- `imem_rsp_err`  in  1: access fault on this response.
- `fd_valid`  out  1: `fd_out` holds a valid packet.
- `fd_ready`  in  1: decode consumes the packet.
- `fd_out`  out  `fd_interface_t`: `{instr, pc, npc}`.
- `fd_fault`  out  1: packet is a fault; `instr` is 32'h0.
- `fd_fault_misaligned`  out  1: fault cause is a misaligned PC; 0 means a bus error.

## Operation
- Single output register, at most one outstanding memory request. `npc = pc + 4`, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- FSM states:
  - `S_REQ`
    - Condition `pc[1:0] != 0`: load a fault packet (`fd_fault=1`, `fd_fault_misaligned=1`, `instr=0`), no request, go to `S_HALT`.
    - Otherwise, assert `imem_req_valid` only when the output register is free (`!fd_valid || fd_ready`). On `req_valid && req_ready`, go to `S_WAIT`.
  - `S_WAIT`
    - On `imem_rsp_valid`, load the output register with `{rsp_data, pc, pc+4}` and set `fd_fault = rsp_err`.
    - If `rsp_err`, go to `S_HALT`; otherwise set `pc <= pc+4` and go to `S_REQ`.
  - `S_DROP`: a redirect arrived while a request was outstanding. On `imem_rsp_valid`, discard the response and go to `S_REQ`.
  - `S_HALT`: no requests. Leave only on redirect.
- Redirect, applied in every state:
  - `pc <= redirect_pc`.
  - `fd_valid <= 0`, clearing any unconsumed packet; a packet consumed in the same cycle counts as consumed.
  - Next state:
    - `S_DROP` if a request is outstanding and its response has not arrived this cycle. This includes a request accepted in the same cycle.
    - `S_REQ` otherwise; a response arriving in the same cycle is discarded.
- Redirect during `S_DROP` updates `pc` and keeps the FSM in `S_DROP`.
- `fd_valid`/`fd_out` are stable while `fd_valid && !fd_ready` and no redirect is present.

## Timing
- Reset values:
  - `pc = RESET_PC`, state `S_REQ`.
  - `fd_valid = 0`, `fd_fault = 0`, `fd_fault_misaligned = 0`, `imem_req_valid = 0`.
  - `fd_out = 0`.
  - Reset overrides redirect.
- `imem_req_valid` is a combinational function of state, `fd_valid`, `fd_ready` and `redirect_valid`. It is forced to 0 in the redirect cycle.
- Latency:
  - Request is issued in the cycle after reset or redirect.
  - `fd_valid` rises the cycle after `imem_rsp_valid`.
  - Back-to-back throughput with a 1-cycle memory: one instruction per 2 cycles.
- Fault packets appear 1 cycle after entry into `S_REQ` with a misaligned `pc`.
- Reset mid-`S_WAIT`: the outstanding response is the memory's responsibility. The bus contract requires memory reset alongside the core.

## Structure
- Add `fetch_state_e` (`S_REQ`, `S_WAIT`, `S_DROP`, `S_HALT`, 2 bits) to `core_defs`.
- Add `` `define RESET_PC_DEFAULT 32'h80000000`` to `core_defs`.
- `fd_interface_t` is reused unchanged; fault bits are separate ports.
- No sub-module; a single flat module.

## Test plan
- Reset, then a 1-cycle memory returning 32'h00000013 at every address -> first request at 32'h80000000; packets with `pc` 80000000/80000004, `npc` 80000004/80000008, `fd_fault=0`.
- `fd_ready=0` for 5 cycles with a packet held -> `fd_out` stable, `imem_req_valid=0`; releasing `fd_ready` lets the next request issue the same cycle.
- Redirect to 32'h80000100 while in `S_WAIT`, with the response arriving 3 cycles later -> that response is dropped; the next packet has `pc=32'h80000100`.
- Redirect in the same cycle as `imem_rsp_valid` -> no packet from the old `pc`; the next request goes to the redirect target.
- Redirect to 32'h80000102 -> no memory request; packet with `fd_fault=1`, `fd_fault_misaligned=1`, `pc=32'h80000102`, `instr=0`; FSM halts until redirect to 32'h80000000, then fetching resumes.
- Response with `imem_rsp_err=1` at 32'h80000008 -> fault packet with `fd_fault_misaligned=0` and `pc=32'h80000008`; no further requests.
